// File: rtl/car_pkg.sv
// Shared encodings for the car top level: drive modes, command bit positions
// and the power/mode arbiter state set.
package car_pkg;

   // Drive mode encodings as seen on mode_signal and in the arbiter target
   localparam logic [1:0] MODE_NONE   = 2'b00;
   localparam logic [1:0] MODE_MANUAL = 2'b01;
   localparam logic [1:0] MODE_SEMI   = 2'b10;
   localparam logic [1:0] MODE_AUTO   = 2'b11;

   // Bit positions inside every 4-bit move command
   localparam int CMD_LEFT  = 3;
   localparam int CMD_RIGHT = 2;
   localparam int CMD_BACK  = 1;
   localparam int CMD_FWD   = 0;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_ARMING,
      ST_IDLE,
      ST_SWITCH,
      ST_RUN
   } arb_state_e;

   // One-hot grant vector: [0] manual, [1] semi-auto, [2] auto, none -> 0
   function automatic logic [2:0] mode_onehot(input logic [1:0] mode);
      logic [2:0] oh;
      oh = 3'b000;
      case (mode)
         MODE_MANUAL: oh = 3'b001;
         MODE_SEMI:   oh = 3'b010;
         MODE_AUTO:   oh = 3'b100;
         default:     oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (buttons, switches).
// Multi-bit use is only safe for slowly changing levels such as mode_signal,
// where a one-cycle mixed sample is absorbed by the arbiter's dead-time gap.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two-stage capture of the raw input into the clock domain
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: both stages reset to 0, so a button held through reset is
         // seen low for two cycles first and counts as a fresh press.
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep this a true two-flop chain; with
         // blocking ones sync_q would take d_i in the same edge and the
         // first stage would vanish.
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/drive_mode_arbiter.sv
// Power and drive-mode arbiter for the car top level. Qualifies the power-on
// button with a hold-to-start interval, handles power-off and manual stalls,
// grants exactly one drive sub-block at a time and forwards only that
// block's move command, with an all-zero dead-time gap on every mode change.
module drive_mode_arbiter
   import car_pkg::*;
#(
   parameter int HOLD_CYCLES = 100_000_000,
   parameter int SWITCH_GAP  = 16,          // must be at least 1
   parameter int CNT_W       = 27           // 2**CNT_W > HOLD_CYCLES
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       power_on,
   input  logic       power_off,
   input  logic [1:0] mode_signal,
   input  logic [3:0] man_cmd,
   input  logic [3:0] semi_cmd,
   input  logic [3:0] auto_cmd,
   input  logic       man_fault,
   output logic       power_on_led,
   output logic [2:0] mode_led,
   output logic [2:0] mode_en,
   output logic       switching,
   output logic [3:0] cmd_out
);

   // ARMING commits on the edge after HOLD_CYCLES high cycles were counted;
   // SWITCH holds switching high for exactly SWITCH_GAP cycles.
   localparam logic [CNT_W-1:0] HOLD_DONE = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] GAP_DONE  = CNT_W'(SWITCH_GAP - 1);

   logic       pon_s;
   logic       poff_s;
   logic [1:0] mode_s;

   sync_2ff #(.WIDTH(1)) u_sync_pon (
      .clk_i  (sys_clk),
      .rst_ni (rst_n),
      .d_i    (power_on),
      .q_o    (pon_s)
   );

   sync_2ff #(.WIDTH(1)) u_sync_poff (
      .clk_i  (sys_clk),
      .rst_ni (rst_n),
      .d_i    (power_off),
      .q_o    (poff_s)
   );

   sync_2ff #(.WIDTH(2)) u_sync_mode (
      .clk_i  (sys_clk),
      .rst_ni (rst_n),
      .d_i    (mode_signal),
      .q_o    (mode_s)
   );

   arb_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;          // shared hold / gap counter
   logic [CNT_W-1:0] cnt_inc;        // saturating increment of cnt_q
   logic [1:0]       target_q;       // pending mode in SWITCH, grant in RUN
   logic             pon_low_seen_q; // button released since last arming
   logic             power_on_led_q;
   logic             switching_q;
   logic [2:0]       mode_oh_q;
   logic [3:0]       cmd_out_q;
   logic [3:0]       grant_cmd;

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   // Command of the currently granted block; other blocks never reach cmd_out
   always_comb begin
      grant_cmd = 4'b0000;
      case (target_q)
         MODE_MANUAL: grant_cmd = man_cmd;
         MODE_SEMI:   grant_cmd = semi_cmd;
         MODE_AUTO:   grant_cmd = auto_cmd;
         default:     grant_cmd = 4'b0000;
      endcase
   end

   // Arbiter FSM; outputs are registered from the state being entered
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_OFF;
         cnt_q          <= '0;
         target_q       <= MODE_NONE;
         pon_low_seen_q <= 1'b0;
         power_on_led_q <= 1'b0;
         switching_q    <= 1'b0;
         mode_oh_q      <= 3'b000;
         cmd_out_q      <= 4'b0000;
      end else begin
         // Defaults: outputs low, counter advances; branches override below
         pon_low_seen_q <= pon_low_seen_q | ~pon_s;
         cnt_q          <= cnt_inc;
         power_on_led_q <= 1'b0;
         switching_q    <= 1'b0;
         mode_oh_q      <= 3'b000;
         cmd_out_q      <= 4'b0000;

         if (state_q != ST_OFF && poff_s) begin
            // Power-off wins over everything, including a held power_on
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            target_q <= MODE_NONE;
         end else begin
            case (state_q)
               ST_OFF: begin
                  cnt_q <= '0;
                  if (pon_s && !poff_s && pon_low_seen_q) begin
                     state_q        <= ST_ARMING;
                     pon_low_seen_q <= 1'b0;
                  end
               end

               ST_ARMING: begin
                  if (!pon_s) begin
                     state_q <= ST_OFF;
                     cnt_q   <= '0;
                  end else if (cnt_q == HOLD_DONE) begin
                     state_q        <= ST_IDLE;
                     cnt_q          <= '0;
                     power_on_led_q <= 1'b1;
                  end
               end

               ST_IDLE: begin
                  power_on_led_q <= 1'b1;
                  if (mode_s != MODE_NONE) begin
                     state_q     <= ST_SWITCH;
                     target_q    <= mode_s;
                     cnt_q       <= '0;
                     switching_q <= 1'b1;
                  end
               end

               ST_SWITCH: begin
                  power_on_led_q <= 1'b1;
                  if (mode_s != target_q) begin
                     // Selector moved again: restart the full dead time
                     target_q    <= mode_s;
                     cnt_q       <= '0;
                     switching_q <= 1'b1;
                  end else if (cnt_q == GAP_DONE) begin
                     cnt_q <= '0;
                     if (target_q == MODE_NONE) begin
                        state_q <= ST_IDLE;
                     end else begin
                        state_q   <= ST_RUN;
                        mode_oh_q <= mode_onehot(target_q);
                     end
                  end else begin
                     switching_q <= 1'b1;
                  end
               end

               ST_RUN: begin
                  power_on_led_q <= 1'b1;
                  if (man_fault && target_q == MODE_MANUAL) begin
                     // Manual block requested an engine stall
                     state_q        <= ST_OFF;
                     cnt_q          <= '0;
                     target_q       <= MODE_NONE;
                     power_on_led_q <= 1'b0;
                  end else if (mode_s != target_q) begin
                     state_q     <= ST_SWITCH;
                     target_q    <= mode_s;
                     cnt_q       <= '0;
                     switching_q <= 1'b1;
                  end else begin
                     mode_oh_q <= mode_onehot(target_q);
                     cmd_out_q <= grant_cmd;
                  end
               end

               default: begin
                  state_q  <= ST_OFF;
                  cnt_q    <= '0;
                  target_q <= MODE_NONE;
               end
            endcase
         end
      end
   end

   assign power_on_led = power_on_led_q;
   assign mode_led     = mode_oh_q;
   assign mode_en      = mode_oh_q;
   assign switching    = switching_q;
   assign cmd_out      = cmd_out_q;

endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Self-checking bench for drive_mode_arbiter with HOLD_CYCLES=10, SWITCH_GAP=4.
// A behavioural model tracks "engine on", the arming run length, the number
// of dead-time cycles left and the current grant, and predicts every output
// at each falling edge. Directed scenarios are followed by random traffic.
module tb_drive_mode_arbiter;

   localparam int HOLD = 10;
   localparam int GAP  = 4;

   logic       sys_clk;
   logic       rst_n;
   logic       power_on;
   logic       power_off;
   logic [1:0] mode_signal;
   logic [3:0] man_cmd;
   logic [3:0] semi_cmd;
   logic [3:0] auto_cmd;
   logic       man_fault;
   logic       power_on_led;
   logic [2:0] mode_led;
   logic [2:0] mode_en;
   logic       switching;
   logic [3:0] cmd_out;

   int checks   = 0;
   int failures = 0;

   drive_mode_arbiter #(
      .HOLD_CYCLES (HOLD),
      .SWITCH_GAP  (GAP),
      .CNT_W       (8)
   ) dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .power_on     (power_on),
      .power_off    (power_off),
      .mode_signal  (mode_signal),
      .man_cmd      (man_cmd),
      .semi_cmd     (semi_cmd),
      .auto_cmd     (auto_cmd),
      .man_fault    (man_fault),
      .power_on_led (power_on_led),
      .mode_led     (mode_led),
      .mode_en      (mode_en),
      .switching    (switching),
      .cmd_out      (cmd_out)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ---------------- behavioural model ----------------
   logic       pon_h  [2];
   logic       poff_h [2];
   logic [1:0] mode_h [2];
   bit         m_on;        // engine running (IDLE, SWITCH or RUN)
   bit         m_released;  // button seen released since last arming
   int         m_arm;       // high cycles counted while arming, -1 if not arming
   int         m_gap_left;  // dead-time cycles still to show, 0 outside the gap
   int         m_target;
   int         m_grant;     // 0 none, 1 manual, 2 semi, 3 auto
   logic [3:0] m_cmd;

   function automatic logic [2:0] onehot_of(input int m);
      return (m == 0) ? 3'b000 : 3'(1 << (m - 1));
   endfunction

   task automatic model_off();
      m_on       = 1'b0;
      m_arm      = -1;
      m_gap_left = 0;
      m_grant    = 0;
      m_target   = 0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         pon_h[k]  = 1'b0;
         poff_h[k] = 1'b0;
         mode_h[k] = 2'b00;
      end
      model_off();
      m_released = 1'b0;
      m_cmd      = 4'h0;
   endtask

   // Advance the model by one rising edge, using the synchronized view
   task automatic model_step();
      bit ps;
      bit pf;
      int ms;
      ps = pon_h[1];
      pf = poff_h[1];
      ms = int'(mode_h[1]);
      pon_h[1]  = pon_h[0];  pon_h[0]  = power_on;
      poff_h[1] = poff_h[0]; poff_h[0] = power_off;
      mode_h[1] = mode_h[0]; mode_h[0] = mode_signal;
      m_cmd = 4'h0;
      if (!ps) m_released = 1'b1;
      if (pf && (m_on || m_arm >= 0)) begin
         model_off();
      end else if (m_arm >= 0) begin
         if (!ps) m_arm = -1;
         else if (m_arm == HOLD) begin m_arm = -1; m_on = 1'b1; end
         else m_arm++;
      end else if (!m_on) begin
         if (ps && !pf && m_released) begin m_arm = 0; m_released = 1'b0; end
      end else if (m_gap_left > 0) begin
         if (ms != m_target) begin m_target = ms; m_gap_left = GAP; end
         else if (m_gap_left == 1) begin m_gap_left = 0; m_grant = m_target; end
         else m_gap_left--;
      end else if (m_grant != 0) begin
         if (man_fault && m_grant == 1) model_off();
         else if (ms != m_grant) begin m_grant = 0; m_target = ms; m_gap_left = GAP; end
         else m_cmd = (m_grant == 1) ? man_cmd : (m_grant == 2) ? semi_cmd : auto_cmd;
      end else if (ms != 0) begin
         m_target = ms; m_gap_left = GAP;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [2:0] exp_oh;
      exp_oh = (m_on && m_gap_left == 0) ? onehot_of(m_grant) : 3'b000;
      check("power_on_led", 8'(power_on_led), 8'(m_on));
      check("mode_led", 8'(mode_led), 8'(exp_oh));
      check("mode_en", 8'(mode_en), 8'(exp_oh));
      check("switching", 8'(switching), 8'(m_gap_left > 0));
      check("cmd_out", 8'(cmd_out), 8'(m_cmd));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_led"}, 8'(power_on_led), 8'h00);
      check({tag, "_mode_led"}, 8'(mode_led), 8'h00);
      check({tag, "_mode_en"}, 8'(mode_en), 8'h00);
      check({tag, "_switching"}, 8'(switching), 8'h00);
      check({tag, "_cmd"}, 8'(cmd_out), 8'h00);
   endtask

   // One clock: model follows the rising edge, outputs compared on the falling edge
   task automatic cycle();
      @(posedge sys_clk);
      model_step();
      @(negedge sys_clk);
      compare_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Hard bound on total run time
   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int first_on;
      int led_seen;
      int sw_cnt;
      int first_run;
      logic [3:0] cmd_at_entry;

      rst_n       = 1'b0;
      power_on    = 1'b0;
      power_off   = 1'b0;
      mode_signal = 2'b00;
      man_cmd     = 4'h0;
      semi_cmd    = 4'h0;
      auto_cmd    = 4'h0;
      man_fault   = 1'b0;
      model_reset();
      repeat (3) @(negedge sys_clk);
      check_all_zero("reset");

      // Short press: released after edge 8, engine must stay off
      rst_n    = 1'b1;
      power_on = 1'b1;
      run(9);
      power_on = 1'b0;
      led_seen = 0;
      for (int e = 0; e < 8; e++) begin
         cycle();
         if (power_on_led) led_seen = 1;
      end
      check("short_press_led", 8'(led_seen), 8'h00);

      // Full hold: LED rises right after edge 13
      power_on = 1'b1;
      first_on = -1;
      for (int e = 0; e < 20; e++) begin
         cycle();
         if (power_on_led && first_on < 0) first_on = e;
      end
      check("hold_edge", 8'(first_on), 8'd13);

      // Manual grant; other blocks' commands must never leak
      mode_signal = 2'b01;
      man_cmd     = 4'b0001;
      sw_cnt      = 0;
      first_run   = -1;
      cmd_at_entry = 4'hf;
      for (int e = 0; e < 10; e++) begin
         semi_cmd = 4'($urandom);
         auto_cmd = 4'($urandom);
         cycle();
         if (switching) sw_cnt++;
         if (mode_led == 3'b001 && first_run < 0) begin
            first_run    = e;
            cmd_at_entry = cmd_out;
         end
      end
      check("gap_len_manual", 8'(sw_cnt), 8'd4);
      check("run_entry_cmd", 8'(cmd_at_entry), 8'h00);
      check("manual_en", 8'(mode_en), 8'b001);
      check("manual_cmd", 8'(cmd_out), 8'b0001);

      // Manual -> auto: command cut within 3 edges, then auto command
      mode_signal = 2'b11;
      auto_cmd    = 4'b1010;
      run(3);
      check("cut_cmd", 8'(cmd_out), 8'h00);
      run(8);
      check("auto_led", 8'(mode_led), 8'b100);
      check("auto_cmd", 8'(cmd_out), 8'b1010);

      // Gap restart 10 -> 01 ends in manual
      mode_signal = 2'b10;
      run(4);
      mode_signal = 2'b01;
      run(12);
      check("restart_led", 8'(mode_led), 8'b001);

      // Gap ending on 00 returns to IDLE
      mode_signal = 2'b11;
      run(4);
      mode_signal = 2'b00;
      run(12);
      check("idle_led", 8'(mode_led), 8'h00);
      check("idle_power", 8'(power_on_led), 8'h01);

      // Power-off while power_on is still held: off, and no re-arm
      mode_signal = 2'b01;
      run(12);
      power_off = 1'b1;
      run(3);
      check_all_zero("poff");
      power_off = 1'b0;
      run(20);
      check("no_rearm", 8'(power_on_led), 8'h00);

      // Both buttons together while OFF: stays OFF
      power_on = 1'b0;
      run(3);
      power_on  = 1'b1;
      power_off = 1'b1;
      run(20);
      check("both_off", 8'(power_on_led), 8'h00);
      power_off = 1'b0;
      run(20);
      check("rearm_on", 8'(power_on_led), 8'h01);

      // man_fault in RUN manual stalls the engine
      run(12);
      man_fault = 1'b1;
      cycle();
      man_fault = 1'b0;
      run(2);
      check("fault_manual", 8'(power_on_led), 8'h00);

      // Same pulse in RUN auto is ignored
      mode_signal = 2'b11;
      power_on    = 1'b0;
      run(3);
      power_on = 1'b1;
      run(16);
      run(12);
      man_fault = 1'b1;
      cycle();
      man_fault = 1'b0;
      run(2);
      check("fault_auto_led", 8'(power_on_led), 8'h01);
      check("fault_auto_mode", 8'(mode_led), 8'b100);

      // Asynchronous reset in the middle of a gap
      mode_signal = 2'b10;
      run(4);
      check("pre_reset_gap", 8'(switching), 8'h01);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      model_reset();
      @(negedge sys_clk);
      rst_n = 1'b1;

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         man_cmd  = 4'($urandom);
         semi_cmd = 4'($urandom);
         auto_cmd = 4'($urandom);
         if ($urandom_range(0, 11) == 0) mode_signal = 2'($urandom_range(0, 3));
         power_on  = ($urandom_range(0, 24) != 0);
         power_off = ($urandom_range(0, 199) == 0);
         man_fault = ($urandom_range(0, 49) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
